// File: rtl/cc_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cc_config_sequencer
// Description : Double-buffered configuration sequencer for the colour
//               combiner. Software writes CC_MODE / CONST_COLOR into shadow
//               registers at any time; a commit pulse stops new fragment
//               launches, waits for the combiner pipeline to drain, then
//               copies shadow to active in a single SWAP cycle. This way no
//               fragment ever sees a mix of old and new configuration.
//
// Parameters  : INFLIGHT_MAX  - max fragments inside the combiner (1..7)
//               RESET_CC_MODE - active/shadow cc_mode value after reset
//
// Ports       : clk, rst_n                    - clock, async active-low reset
//               wr_cc_mode_valid/wr_cc_mode   - shadow CC_MODE write
//               wr_const_valid/wr_const       - shadow CONST_COLOR write
//               commit                        - request shadow->active swap
//               up_valid/up_ready             - upstream fragment handshake
//               cc_frag_valid/cc_in_ready     - launch into colour combiner
//               cc_out_valid/cc_out_ready     - combiner output (observed)
//               cc_mode/const_color           - active configuration
//               busy                          - FSM not idle
//               inflight                      - fragments in the combiner
//               drain_timeout                 - sticky watchdog flag
//                                               (only with CC_SEQ_WATCHDOG_EN)
//
// Build option: CC_SEQ_WATCHDOG_EN - adds an 8-bit DRAIN watchdog that forces
//               the swap after 255 DRAIN cycles and sets drain_timeout.
//
// Revision    : 1.0 - initial release
// ============================================================================
module cc_config_sequencer #(
    parameter int unsigned INFLIGHT_MAX  = 4,
    parameter logic [63:0] RESET_CC_MODE = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_cc_mode_valid,
    input  logic [63:0] wr_cc_mode,
    input  logic        wr_const_valid,
    input  logic [63:0] wr_const,
    input  logic        commit,
    input  logic        up_valid,
    output logic        up_ready,
    output logic        cc_frag_valid,
    input  logic        cc_in_ready,
    input  logic        cc_out_valid,
    input  logic        cc_out_ready,
    output logic [63:0] cc_mode,
    output logic [63:0] const_color,
    output logic        busy,
`ifdef CC_SEQ_WATCHDOG_EN
    output logic        drain_timeout,
`endif
    output logic [2:0]  inflight
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    localparam logic [2:0] C_INFLIGHT_MAX = 3'(INFLIGHT_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_inflight;
    logic [63:0] r_shadow_mode;
    logic [63:0] r_shadow_const;
    logic [63:0] r_cc_mode;
    logic [63:0] r_const_color;
    logic        w_gate;
    logic        w_launch;
    logic        w_retire;

    // Launches are only allowed while idle, so anything launched has been
    // issued against the currently active configuration.
    assign w_gate        = (r_state == ST_IDLE) && (r_inflight < C_INFLIGHT_MAX);
    assign cc_frag_valid = up_valid & w_gate;
    assign up_ready      = cc_in_ready & w_gate;
    assign w_launch      = up_valid & up_ready;
    assign w_retire      = cc_out_valid & cc_out_ready;

    assign busy        = (r_state != ST_IDLE);
    assign inflight    = r_inflight;
    assign cc_mode     = r_cc_mode;
    assign const_color = r_const_color;

`ifdef CC_SEQ_WATCHDOG_EN
    logic [7:0] r_drain_cnt;
    logic       r_drain_timeout;
    logic       w_wd_force;

    assign drain_timeout = r_drain_timeout;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
`ifdef CC_SEQ_WATCHDOG_EN
        w_wd_force  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (commit) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // commit here is merged into the pending swap
                if (r_inflight == 3'd0) begin
                    w_state_nxt = ST_SWAP;
`ifdef CC_SEQ_WATCHDOG_EN
                end else if (r_drain_cnt == 8'd254) begin
                    // counter holds 254 during the 255th DRAIN cycle
                    w_state_nxt = ST_SWAP;
                    w_wd_force  = 1'b1;
`endif
                end
            end
            ST_SWAP: begin
                // a commit arriving during the swap starts a fresh drain so
                // the shadow write that came with it gets its own swap
                w_state_nxt = commit ? ST_DRAIN : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // In-flight counter: saturates at 0 on stray retires; the launch gate
    // keeps it from exceeding INFLIGHT_MAX.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 3'd0;
        end else begin
            case ({w_launch, w_retire})
                2'b10:   r_inflight <= r_inflight + 3'd1;
                2'b01:   r_inflight <= (r_inflight != 3'd0) ? r_inflight - 3'd1 : 3'd0;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shadow and active configuration. The active copy samples the shadow
    // values held at the start of SWAP; a write in the SWAP cycle itself
    // only reaches the shadow.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_mode  <= RESET_CC_MODE;
            r_shadow_const <= 64'h0;
            r_cc_mode      <= RESET_CC_MODE;
            r_const_color  <= 64'h0;
        end else begin
            if (wr_cc_mode_valid) begin
                r_shadow_mode <= wr_cc_mode;
            end
            if (wr_const_valid) begin
                r_shadow_const <= wr_const;
            end
            if (r_state == ST_SWAP) begin
                r_cc_mode     <= r_shadow_mode;
                r_const_color <= r_shadow_const;
            end
        end
    end

`ifdef CC_SEQ_WATCHDOG_EN
    // ------------------------------------------------------------------
    // DRAIN watchdog: counts consecutive DRAIN cycles, restarts on entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt     <= 8'd0;
            r_drain_timeout <= 1'b0;
        end else begin
            if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DRAIN)) begin
                r_drain_cnt <= r_drain_cnt + 8'd1;
            end else begin
                r_drain_cnt <= 8'd0;
            end
            if (w_wd_force) begin
                r_drain_timeout <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cc_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_config_sequencer
// Description : Self-checking bench for cc_config_sequencer. A table of
//               per-cycle input records and expected outputs covers launch
//               gating, in-flight counting, drain/swap and commit-in-SWAP;
//               hand-written sequences cover reset in DRAIN and, when
//               CC_SEQ_WATCHDOG_EN is defined, the DRAIN watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_config_sequencer;

    localparam logic [63:0] C_RST_MODE = 64'hA5A5_0000_0000_005A;
    localparam logic [63:0] C_MODE_A   = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] C_MODE_B   = 64'h0000_0000_0000_0077;
    localparam logic [63:0] C_CONST_K  = 64'h1000_1000_1000_1000;

    logic        clk;
    logic        rst_n;
    logic        wr_cc_mode_valid;
    logic [63:0] wr_cc_mode;
    logic        wr_const_valid;
    logic [63:0] wr_const;
    logic        commit;
    logic        up_valid;
    logic        up_ready;
    logic        cc_frag_valid;
    logic        cc_in_ready;
    logic        cc_out_valid;
    logic        cc_out_ready;
    logic [63:0] cc_mode;
    logic [63:0] const_color;
    logic        busy;
    logic [2:0]  inflight;
`ifdef CC_SEQ_WATCHDOG_EN
    logic        drain_timeout;
`endif

    cc_config_sequencer #(
        .INFLIGHT_MAX  (4),
        .RESET_CC_MODE (C_RST_MODE)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_cc_mode_valid (wr_cc_mode_valid),
        .wr_cc_mode       (wr_cc_mode),
        .wr_const_valid   (wr_const_valid),
        .wr_const         (wr_const),
        .commit           (commit),
        .up_valid         (up_valid),
        .up_ready         (up_ready),
        .cc_frag_valid    (cc_frag_valid),
        .cc_in_ready      (cc_in_ready),
        .cc_out_valid     (cc_out_valid),
        .cc_out_ready     (cc_out_ready),
        .cc_mode          (cc_mode),
        .const_color      (const_color),
        .busy             (busy),
`ifdef CC_SEQ_WATCHDOG_EN
        .drain_timeout    (drain_timeout),
`endif
        .inflight         (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        uv, cir, cov, cor, cm, wmv, wcv;
        logic [63:0] wm, wc;
        logic        e_ur, e_fv, e_busy;
        logic [2:0]  e_infl;
        logic [63:0] e_mode, e_const;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic uv, cir, cov, cor, cm,
                       input logic wmv, input logic [63:0] wm,
                       input logic wcv, input logic [63:0] wc,
                       input logic e_ur, e_fv, e_busy, input logic [2:0] e_infl,
                       input logic [63:0] e_mode, e_const);
        vec_t v;
        v.uv = uv; v.cir = cir; v.cov = cov; v.cor = cor; v.cm = cm;
        v.wmv = wmv; v.wm = wm; v.wcv = wcv; v.wc = wc;
        v.e_ur = e_ur; v.e_fv = e_fv; v.e_busy = e_busy; v.e_infl = e_infl;
        v.e_mode = e_mode; v.e_const = e_const;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        up_valid = 1'b0; cc_in_ready = 1'b1; cc_out_valid = 1'b0; cc_out_ready = 1'b0;
        commit = 1'b0; wr_cc_mode_valid = 1'b0; wr_cc_mode = '0;
        wr_const_valid = 1'b0; wr_const = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle_inputs();
        up_valid = 1'b1;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // during reset up_ready follows cc_in_ready
        check("rst up_ready", {63'd0, up_ready}, 64'd1);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst inflight", {61'd0, inflight}, 64'd0);
        check("rst cc_mode", cc_mode, C_RST_MODE);
        check("rst const_color", const_color, 64'd0);

        //   uv cir cov cor cm  wmv wm        wcv wc         ur fv bsy infl mode        const
        add(1, 1, 0, 0, 0,  0, 0,         0, 0,          1, 1, 0, 0, C_RST_MODE, 0);
        add(1, 1, 0, 0, 0,  0, 0,         0, 0,          1, 1, 0, 1, C_RST_MODE, 0);
        add(1, 1, 0, 0, 0,  0, 0,         0, 0,          1, 1, 0, 2, C_RST_MODE, 0);
        add(1, 1, 0, 0, 0,  0, 0,         0, 0,          1, 1, 0, 3, C_RST_MODE, 0);
        add(1, 1, 0, 0, 0,  0, 0,         0, 0,          0, 0, 0, 4, C_RST_MODE, 0);
        add(1, 1, 1, 1, 0,  0, 0,         0, 0,          0, 0, 0, 4, C_RST_MODE, 0);
        add(0, 1, 1, 1, 0,  0, 0,         0, 0,          1, 0, 0, 3, C_RST_MODE, 0);
        add(1, 1, 1, 1, 0,  0, 0,         0, 0,          1, 1, 0, 2, C_RST_MODE, 0);
        add(0, 0, 0, 0, 0,  1, C_MODE_A,  0, 0,          0, 0, 0, 2, C_RST_MODE, 0);
        add(0, 1, 0, 0, 1,  0, 0,         0, 0,          1, 0, 0, 2, C_RST_MODE, 0);
        add(1, 1, 1, 1, 0,  0, 0,         0, 0,          0, 0, 1, 2, C_RST_MODE, 0);
        add(1, 1, 1, 1, 0,  0, 0,         0, 0,          0, 0, 1, 1, C_RST_MODE, 0);
        add(1, 1, 0, 0, 0,  0, 0,         0, 0,          0, 0, 1, 0, C_RST_MODE, 0);
        add(0, 1, 1, 1, 0,  0, 0,         0, 0,          0, 0, 1, 0, C_RST_MODE, 0);
        add(0, 1, 1, 1, 0,  0, 0,         0, 0,          1, 0, 0, 0, C_MODE_A,   0);
        add(0, 1, 0, 0, 1,  0, 0,         0, 0,          1, 0, 0, 0, C_MODE_A,   0);
        add(0, 1, 0, 0, 0,  1, C_MODE_B,  0, 0,          0, 0, 1, 0, C_MODE_A,   0);
        add(0, 1, 0, 0, 1,  0, 0,         1, C_CONST_K,  0, 0, 1, 0, C_MODE_A,   0);
        add(0, 1, 0, 0, 0,  0, 0,         0, 0,          0, 0, 1, 0, C_MODE_B,   0);
        add(0, 1, 0, 0, 0,  0, 0,         0, 0,          0, 0, 1, 0, C_MODE_B,   0);
        add(1, 1, 0, 0, 0,  0, 0,         0, 0,          1, 1, 0, 0, C_MODE_B,   C_CONST_K);
        add(0, 1, 0, 0, 0,  0, 0,         0, 0,          1, 0, 0, 1, C_MODE_B,   C_CONST_K);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            up_valid = vecs[i].uv; cc_in_ready = vecs[i].cir;
            cc_out_valid = vecs[i].cov; cc_out_ready = vecs[i].cor;
            commit = vecs[i].cm;
            wr_cc_mode_valid = vecs[i].wmv; wr_cc_mode = vecs[i].wm;
            wr_const_valid = vecs[i].wcv; wr_const = vecs[i].wc;
            #2;
            check($sformatf("row%0d up_ready", i), {63'd0, up_ready}, {63'd0, vecs[i].e_ur});
            check($sformatf("row%0d cc_frag_valid", i), {63'd0, cc_frag_valid}, {63'd0, vecs[i].e_fv});
            check($sformatf("row%0d busy", i), {63'd0, busy}, {63'd0, vecs[i].e_busy});
            check($sformatf("row%0d inflight", i), {61'd0, inflight}, {61'd0, vecs[i].e_infl});
            check($sformatf("row%0d cc_mode", i), cc_mode, vecs[i].e_mode);
            check($sformatf("row%0d const_color", i), const_color, vecs[i].e_const);
            @(negedge clk);
        end

        // ---- reset in the middle of DRAIN drops the pending swap ----
        idle_inputs();
        commit = 1'b1;
        wr_cc_mode_valid = 1'b1; wr_cc_mode = 64'hFFFF_0000_FFFF_0000;
        wr_const_valid = 1'b1;   wr_const   = 64'h2;
        @(negedge clk);
        idle_inputs();
        #2;
        check("rd busy before reset", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rd busy in reset", {63'd0, busy}, 64'd0);
        check("rd inflight in reset", {61'd0, inflight}, 64'd0);
        check("rd up_ready in reset", {63'd0, up_ready}, 64'd1);
        check("rd cc_mode in reset", cc_mode, C_RST_MODE);
        @(negedge clk);
        rst_n  = 1'b1;
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        @(negedge clk);
        #2;
        check("rd cc_mode during swap", cc_mode, C_RST_MODE);
        @(negedge clk);
        #2;
        check("rd cc_mode after swap", cc_mode, C_RST_MODE);
        check("rd const after swap", const_color, 64'd0);
        check("rd busy after swap", {63'd0, busy}, 64'd0);

`ifdef CC_SEQ_WATCHDOG_EN
        // ---- watchdog: one fragment never retires ----
        begin
            int n;
            up_valid = 1'b1;
            @(negedge clk);
            up_valid = 1'b0;
            commit   = 1'b1;
            wr_cc_mode_valid = 1'b1; wr_cc_mode = 64'h5555_5555_5555_5555;
            @(posedge clk);
            #1;
            idle_inputs();
            n = 0;
            while (n < 400) begin
                @(posedge clk);
                n++;
                #1;
                if (cc_mode == 64'h5555_5555_5555_5555) break;
            end
            check("wd swap latency", 64'(n), 64'd256);
            check("wd drain_timeout set", {63'd0, drain_timeout}, 64'd1);
            repeat (3) @(posedge clk);
            #1;
            check("wd drain_timeout sticky", {63'd0, drain_timeout}, 64'd1);
            rst_n = 1'b0;
            #1;
            check("wd drain_timeout reset", {63'd0, drain_timeout}, 64'd0);
            rst_n = 1'b1;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cc_config_sequencer.md
CC_CONFIG_SEQUENCER -- requirements
Module: cc_config_sequencer

Interface
REQ-001 SHALL have parameter INFLIGHT_MAX, default 4, meaning max fragments in flight in color_combiner (range 1..7).
REQ-002 SHALL have parameter RESET_CC_MODE, default 64'h0, meaning the active cc_mode value after reset.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_cc_mode_valid / wr_cc_mode  input  1 / 64  shadow CC_MODE write strobe and data.
REQ-006 SHALL have port wr_const_valid / wr_const  input  1 / 64  shadow CONST_COLOR write strobe and data.
REQ-007 SHALL have port commit  input  1  single-cycle pulse at a draw boundary; requests shadow-to-active swap.
REQ-008 SHALL have port up_valid / up_ready  input / output  1 / 1  upstream fragment handshake.
REQ-009 SHALL have port cc_frag_valid / cc_in_ready  output / input  1 / 1  fragment launch into color_combiner.
REQ-010 SHALL have port cc_out_valid / cc_out_ready  input / input  1 / 1  combiner output handshake, observed only.
REQ-011 SHALL have port cc_mode / const_color  output  64 / 64  active configuration driving color_combiner.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port inflight  output  3  current in-flight fragment count.

Function
REQ-014 SHALL implement FSM states IDLE, DRAIN, SWAP; IDLE->DRAIN on commit; DRAIN->SWAP when inflight==0; SWAP->IDLE unconditionally after one cycle.
REQ-015 SHALL take DRAIN->SWAP in the same cycle commit arrives if inflight==0 and no fragment launches (DRAIN lasts one cycle minimum).
REQ-016 SHALL drive gate = (state==IDLE) & (inflight < INFLIGHT_MAX); cc_frag_valid = up_valid & gate; up_ready = cc_in_ready & gate (combinational).
REQ-017 SHALL define launch = up_valid & up_ready and retire = cc_out_valid & cc_out_ready.
REQ-018 SHALL increment inflight on launch only, decrement on retire only, hold on both or neither.
REQ-019 SHALL never wrap inflight: retire at 0 is ignored; launch at INFLIGHT_MAX is impossible by REQ-016.
REQ-020 SHALL update shadow registers on their write strobes in every state; writes are not visible on outputs until a swap.
REQ-021 SHALL, in SWAP, load cc_mode/const_color from shadow values registered before that cycle; a write in the SWAP cycle lands in shadow only.
REQ-022 SHALL ignore commit in DRAIN (merged); commit in SWAP SHALL cause SWAP->DRAIN instead of ->IDLE.
REQ-023 SHALL change cc_mode/const_color only on the SWAP cycle edge; outputs stable otherwise.
REQ-024 SHALL guarantee no fragment launched before commit sees post-swap config, and none launched after commit sees pre-swap config.

Reset
REQ-025 SHALL on rst_n low asynchronously set state=IDLE, inflight=0, cc_mode=RESET_CC_MODE, const_color=0, shadow cc_mode=RESET_CC_MODE, shadow const=0.
REQ-026 SHALL derive up_ready/cc_frag_valid from reset state, so up_ready follows cc_in_ready during reset; busy=0 during reset.
REQ-027 SHALL on reset mid-DRAIN discard the pending swap; shadow contents are lost.

Configuration
REQ-028 SHALL, with CC_SEQ_WATCHDOG_EN defined, add output drain_timeout (1 bit, sticky, reset 0) and an 8-bit DRAIN cycle counter; on reaching 255 in DRAIN, force SWAP and set drain_timeout.
REQ-029 SHALL, without CC_SEQ_WATCHDOG_EN, omit drain_timeout and the counter; DRAIN waits indefinitely.

Verification
REQ-030 Reset, idle: cc_in_ready=1, up_valid=1 -> up_ready=1, cc_mode=RESET_CC_MODE, inflight increments each cycle until 4, then up_ready=0.
REQ-031 Swap with drain: 2 in flight, write wr_cc_mode=64'h1234_5678_9ABC_DEF0, commit -> up_ready=0, busy=1; after 2 retires SWAP; next cycle cc_mode=64'h1234_5678_9ABC_DEF0, busy=0.
REQ-032 Empty commit: inflight=0, commit -> DRAIN 1 cycle, SWAP 1 cycle, cc_mode updated 2 edges after commit.
REQ-033 Simultaneous launch+retire at inflight=2 -> inflight stays 2; retire at 0 -> stays 0.
REQ-034 Commit during SWAP with wr_const=64'h1000_1000_1000_1000 written that cycle -> const_color unchanged at SWAP, FSM to DRAIN, new value after next SWAP.
REQ-035 With CC_SEQ_WATCHDOG_EN: inflight=1 never retired, commit -> SWAP after 255 DRAIN cycles, drain_timeout=1 until reset.
